ysyx_ifu_resp: RTL and testbench
================================

# ysyx_ifu_resp

Instruction-fetch bus responder: the memory-side end of the IFU read interface. It accepts word-fetch requests on the `ifu_ar*` handshake, models a configurable access latency, and returns data on a one-cycle `rvalid` pulse. Both fetch modes of the IFU L1I refill are supported: two single reads per line, or one 2-beat burst. It backs simulation and FPGA builds where instruction memory is on-chip, and has a preload port for program images.

## Interface
- `DATA_W`, 32: data and address width.
- `MEM_LEN`, 12: log2 of memory depth in words (4096 words).
- `BASE`, 'h30000000: byte address of word 0.
- `LATENCY`, 2: cycles from request accept to the first `rvalid`; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ifu_araddr_i`  in  DATA_W  fetch byte address; bits [1:0] ignored.
- `ifu_arvalid_i`  in  1  request valid; held high by the initiator until accepted.
- `ifu_arburst_i`  in  1  sampled at accept: 1 = 2-beat line burst, 0 = single word.
- `ifu_required_i`  in  1  initiator owns the bus; a low level aborts a pending request.
- `ifu_arready_o`  out  1  responder idle, request accepted this cycle if `arvalid`.
- `ifu_rdata_o`  out  DATA_W  read data, valid only while `rvalid` is high.
- `ifu_rvalid_o`  out  1  one-cycle data pulse per beat.
- `ifu_rerr_o`  out  1  qualifies `rvalid`: address out of range, data forced to 0.
- `ld_we_i`  in  1  preload write enable.
- `ld_addr_i`  in  DATA_W  preload byte address (absolute, same map as fetch).
- `ld_wdata_i`  in  DATA_W  preload data.

## Operation
- States: IDLE, WAIT, BEAT0, BEAT1.
- IDLE: `arready`=1. If `arvalid`, then accept:
  - latch word address;
  - latch `burst` = `arburst_i`;
  - latch `oor` = address outside [BASE, BASE+4·2^MEM_LEN);
  - load the down-counter with LATENCY-1;
  - go to WAIT, or straight to BEAT0 if LATENCY=1.
- WAIT: decrement the counter each cycle. At 0, register the read data for the latched address and go to BEAT0.
- BEAT0: `rvalid`=1 for one cycle. If `burst`, go to BEAT1; otherwise go to IDLE.
- BEAT1: `rvalid`=1 with the word at latched address | 4 (the second word of the 8-byte line), then go to IDLE.
- Burst addressing: beat 0 returns address & ~4, beat 1 returns address | 4. The order is independent of address bit 2.
- Non-burst: returns exactly the latched word.
- Out of range: every beat has `rdata`=0 and `rerr`=1. Latency and beat count are unchanged. In a burst, `oor` is evaluated per beat address.
- Preload: when `ld_we_i`=1 and the address is in range, write the word; out-of-range writes are dropped. Preload is legal in any state.
- Write/read collision: a write in the cycle the read data is registered returns the old data. The new data is visible from the next read.
- Abort: `required_i`=0 while in WAIT sends the block to IDLE with no `rvalid`. `required_i` is ignored in BEAT0/BEAT1; a beat always completes.
- `arvalid` in any state other than IDLE is ignored, with no queueing. The initiator must re-present the request.

## Timing
- While `rst`=0 (sampled synchronously): state IDLE, counter 0. Outputs: `arready`=0, `rvalid`=0, `rdata`=0, `rerr`=0.
- `arready` rises in the first cycle with `rst`=1.
- Reset mid-transaction drops the request, with no `rvalid` afterwards. Memory contents are not cleared.
- Accept in cycle T gives `rvalid` at T+LATENCY; the burst second beat is at T+LATENCY+1.
- `arready` is low from T+1 through the last beat cycle and high in the cycle after the last beat.
- Back-to-back: a new accept is possible at the earliest at lastbeat+1.
- `rdata`/`rerr` are registered. They hold their last value when `rvalid`=0, and the bench checks them only under `rvalid`.

## Structure
- Shared package `ysyx_bus_pkg`: state enum `ifu_resp_state_t` {IDLE, WAIT, BEAT0, BEAT1}, and the beat-address helper constant LINE_MASK = 'h4.
- Sub-module `ysyx_ifu_resp_mem`: 1R1W word array of 2^MEM_LEN × DATA_W with a registered read port, plus an in-range compare. The FSM, counter and handshake stay in the top module.

## Test plan
- Preload 'h30000000='h00000413, 'h30000004='h00100493; single fetch of 'h30000004 with LATENCY=2, accepted at T → `rvalid` only at T+2 with rdata='h00100493, `rerr`=0; `arready` back at T+3.
- Burst fetch of 'h30000004 with LATENCY=3, accept T → beat at T+3 = 'h00000413, beat at T+4 = 'h00100493; exactly two pulses.
- Fetch of 'h20000000 (out of range), burst → two beats with rdata=0 and `rerr`=1, same timing as the in-range case.
- `required_i` driven low at T+1 with LATENCY=4 → no `rvalid`; `arready`=1 at T+2; the next request is served normally.
- Preload 'h30000008='hAAAA0000 while fetching 'h30000008 with the write landing in the data-register cycle → 'hAAAA0000 is not returned (old data); a refetch returns 'hAAAA0000.
- `rst`=0 asserted in BEAT0 of a burst → no BEAT1 pulse; all outputs 0 during reset; preloaded data still intact after reset.

Source files
------------

// File: rtl/ysyx_bus_pkg.sv
// Shared types for the IFU fetch responder.
package ysyx_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BEAT0,
      BEAT1
   } ifu_resp_state_t;

   // Selects the second word of an 8-byte refill line.
   localparam logic [31:0] LINE_MASK = 32'h4;

endpackage

// File: rtl/ysyx_ifu_resp_if.sv
// IFU read channel: request handshake, bus ownership and the data beat.
interface ysyx_ifu_resp_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] ifu_araddr_i;
   logic              ifu_arvalid_i;
   logic              ifu_arburst_i;
   logic              ifu_required_i;
   logic              ifu_arready_o;
   logic [DATA_W-1:0] ifu_rdata_o;
   logic              ifu_rvalid_o;
   logic              ifu_rerr_o;

   modport master (
      output ifu_araddr_i, ifu_arvalid_i, ifu_arburst_i, ifu_required_i,
      input  ifu_arready_o, ifu_rdata_o, ifu_rvalid_o, ifu_rerr_o
   );

   modport slave (
      input  ifu_araddr_i, ifu_arvalid_i, ifu_arburst_i, ifu_required_i,
      output ifu_arready_o, ifu_rdata_o, ifu_rvalid_o, ifu_rerr_o
   );
endinterface

// File: rtl/ysyx_ifu_resp_mem.sv
// Word array with a registered read port and a range check on both ports.
// Out-of-range reads return 0 with an error flag; out-of-range writes vanish.
module ysyx_ifu_resp_mem #(
   parameter int              DATA_W  = 32,
   parameter int              MEM_LEN = 12,
   parameter logic [DATA_W-1:0] BASE  = 'h30000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   input  logic              we,
   input  logic [DATA_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);
   localparam int              DEPTH = 1 << MEM_LEN;
   localparam logic [DATA_W-1:0] SPAN = DATA_W'(4 << MEM_LEN);

   logic [DATA_W-1:0] mem [DEPTH];

   function automatic logic in_range(input logic [DATA_W-1:0] a);
      return (a >= BASE) && ((a - BASE) < SPAN);
   endfunction

   function automatic logic [MEM_LEN-1:0] word_idx(input logic [DATA_W-1:0] a);
      return MEM_LEN'((a - BASE) >> 2);
   endfunction

   // Preload write; contents survive reset.
   always_ff @(posedge clk) begin
      if (we && in_range(waddr))
         mem[word_idx(waddr)] <= wdata;
   end

   // Registered read; a same-edge write is not seen (old data returned).
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data <= '0;
         rd_err  <= 1'b0;
      end else if (rd_en) begin
         rd_err  <= !in_range(rd_addr);
         rd_data <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
      end
   end
endmodule

// File: rtl/ysyx_ifu_resp.sv
// IFU fetch responder: accepts one request, waits LATENCY cycles, returns one
// word or a 2-beat line. The read for each beat is issued one cycle ahead so
// the memory's read register lines up with the beat.
module ysyx_ifu_resp
   import ysyx_bus_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter int                MEM_LEN = 12,
   parameter logic [DATA_W-1:0] BASE    = 'h30000000,
   parameter int                LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   ysyx_ifu_resp_if.slave    bus,
   input  logic              ld_we_i,
   input  logic [DATA_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_wdata_i
);
   localparam logic [3:0]        CNT_INIT  = 4'(LATENCY - 1);
   localparam logic [DATA_W-1:0] BEAT_MASK = DATA_W'(LINE_MASK);
   localparam logic [DATA_W-1:0] WORD_MASK = ~DATA_W'(3);

   ifu_resp_state_t   state;
   logic [3:0]        cnt;
   logic [3:0]        cnt_nxt;
   logic              burst_q;
   logic [DATA_W-1:0] addr_q;     // beat-0 word address
   logic [DATA_W-1:0] req_addr;   // beat-0 word address of the incoming request
   logic              rd_en;
   logic [DATA_W-1:0] rd_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rerr;

   assign cnt_nxt = cnt - 4'd1;

   // Bursts always start at the low word of the line.
   always_comb begin
      req_addr = bus.ifu_araddr_i & WORD_MASK;
      if (bus.ifu_arburst_i)
         req_addr = req_addr & ~BEAT_MASK;
   end

   // Issue the memory read in the cycle before each beat.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = addr_q;
      case (state)
         IDLE:  if (bus.ifu_arvalid_i && LATENCY == 1) begin
                   rd_en   = 1'b1;
                   rd_addr = req_addr;
                end
         WAIT:  rd_en = bus.ifu_required_i && (cnt_nxt == 4'd0);
         BEAT0: if (burst_q) begin
                   rd_en   = 1'b1;
                   rd_addr = addr_q | BEAT_MASK;
                end
         default: ;
      endcase
   end

   // Request FSM: accept, latency countdown (abortable), then one or two beats.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         burst_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.ifu_arvalid_i) begin
               addr_q  <= req_addr;
               burst_q <= bus.ifu_arburst_i;
               cnt     <= CNT_INIT;
               state   <= (LATENCY == 1) ? BEAT0 : WAIT;
            end
            WAIT: begin
               if (!bus.ifu_required_i) begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end else if (cnt_nxt == 4'd0) begin
                  state <= BEAT0;
                  cnt   <= 4'd0;
               end else begin
                  cnt   <= cnt_nxt;
               end
            end
            BEAT0:   state <= burst_q ? BEAT1 : IDLE;
            BEAT1:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   ysyx_ifu_resp_mem #(
      .DATA_W  (DATA_W),
      .MEM_LEN (MEM_LEN),
      .BASE    (BASE)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (mem_rdata),
      .rd_err  (mem_rerr),
      .we      (ld_we_i),
      .waddr   (ld_addr_i),
      .wdata   (ld_wdata_i)
   );

   // Outputs are forced low for the whole time reset is held.
   assign bus.ifu_arready_o = rst && (state == IDLE);
   assign bus.ifu_rvalid_o  = rst && ((state == BEAT0) || (state == BEAT1));
   assign bus.ifu_rdata_o   = rst ? mem_rdata : '0;
   assign bus.ifu_rerr_o    = rst && mem_rerr;
endmodule

// File: tb/tb_ysyx_ifu_resp.sv
// Bench for ysyx_ifu_resp: four responders with LATENCY 1..4 driven by the
// same request stream; each one's beats are checked against its own latency.
module tb_ysyx_ifu_resp;
   localparam int NL = 4;

   logic        clk;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arburst;
   logic        required;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;

   logic [NL-1:0]       arready;
   logic [NL-1:0]       rvalid;
   logic [NL-1:0]       rerr;
   logic [NL-1:0][31:0] rdata;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NL; g++) begin : g_dut
      ysyx_ifu_resp_if #(.DATA_W(32)) bus ();
      assign bus.ifu_araddr_i   = araddr;
      assign bus.ifu_arvalid_i  = arvalid;
      assign bus.ifu_arburst_i  = arburst;
      assign bus.ifu_required_i = required;
      assign arready[g] = bus.ifu_arready_o;
      assign rvalid[g]  = bus.ifu_rvalid_o;
      assign rerr[g]    = bus.ifu_rerr_o;
      assign rdata[g]   = bus.ifu_rdata_o;

      ysyx_ifu_resp #(
         .DATA_W  (32),
         .MEM_LEN (12),
         .BASE    (32'h30000000),
         .LATENCY (g + 1)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .bus        (bus),
         .ld_we_i    (ld_we),
         .ld_addr_i  (ld_addr),
         .ld_wdata_i (ld_wdata)
      );
   end

   typedef struct {
      logic [31:0] addr;
      logic        burst;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        err;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } ld_t;

   vec_t vecs [10];
   ld_t  lds  [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request, optionally aborted in cycle T+1, optionally with a preload
   // write in cycle T+wr_k. d0 is per responder (index = LATENCY-1).
   task automatic do_req(input logic [31:0] addr, input logic burst,
                         input logic [NL-1:0][31:0] d0, input logic [31:0] d1,
                         input logic err, input bit abort, input int wr_k,
                         input logic [31:0] wa, input logic [31:0] wd);
      @(posedge clk); #1;
      araddr = addr; arburst = burst; arvalid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NL; i++)
         chk($sformatf("arready_T a=%h L=%0d", addr, i + 1), 32'(arready[i]), 32'd1);
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         arvalid  = 1'b0;
         required = !(abort && k == 1);
         ld_we    = (k == wr_k);
         ld_addr  = wa;
         ld_wdata = wd;
         @(negedge clk);
         for (int i = 0; i < NL; i++) begin
            int lat = i + 1;
            bit ab  = abort && lat > 1;
            bit b0  = !ab && k == lat;
            bit b1  = !ab && burst && k == lat + 1;
            bit rdy = ab ? (k >= 2) : (k > lat + int'(burst));
            chk($sformatf("rvalid a=%h L=%0d k=%0d", addr, lat, k), 32'(rvalid[i]), 32'(b0 || b1));
            chk($sformatf("arready a=%h L=%0d k=%0d", addr, lat, k), 32'(arready[i]), 32'(rdy));
            if (b0) begin
               chk($sformatf("rdata0 a=%h L=%0d", addr, lat), rdata[i], d0[i]);
               chk($sformatf("rerr0 a=%h L=%0d", addr, lat), 32'(rerr[i]), 32'(err));
            end
            if (b1) begin
               chk($sformatf("rdata1 a=%h L=%0d", addr, lat), rdata[i], d1);
               chk($sformatf("rerr1 a=%h L=%0d", addr, lat), 32'(rerr[i]), 32'(err));
            end
         end
      end
      required = 1'b1;
      ld_we    = 1'b0;
   endtask

   initial begin
      lds[0] = '{32'h30000000, 32'h00000413};
      lds[1] = '{32'h30000004, 32'h00100493};
      lds[2] = '{32'h30000008, 32'h11111111};
      lds[3] = '{32'h3000000C, 32'h2222222C};
      lds[4] = '{32'h30003FF8, 32'h5A5A5A5A};
      lds[5] = '{32'h30003FFC, 32'hDEADBEEF};
      lds[6] = '{32'h30004000, 32'hFFFFFFFF};  // dropped: one past the end
      lds[7] = '{32'h2FFFFFFC, 32'hEEEEEEEE};  // dropped: below base

      vecs[0] = '{32'h30000004, 1'b0, 32'h00100493, 32'h0,        1'b0};
      vecs[1] = '{32'h30000004, 1'b1, 32'h00000413, 32'h00100493, 1'b0};
      vecs[2] = '{32'h30000000, 1'b1, 32'h00000413, 32'h00100493, 1'b0};
      vecs[3] = '{32'h20000000, 1'b1, 32'h0,        32'h0,        1'b1};
      vecs[4] = '{32'h30000006, 1'b0, 32'h00100493, 32'h0,        1'b0};
      vecs[5] = '{32'h30003FFC, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[6] = '{32'h30003FFC, 1'b1, 32'h5A5A5A5A, 32'hDEADBEEF, 1'b0};
      vecs[7] = '{32'h30004000, 1'b0, 32'h0,        32'h0,        1'b1};
      vecs[8] = '{32'h2FFFFFFC, 1'b1, 32'h0,        32'h0,        1'b1};
      vecs[9] = '{32'h3000000C, 1'b0, 32'h2222222C, 32'h0,        1'b0};

      rst = 1'b0; araddr = '0; arvalid = 1'b0; arburst = 1'b0; required = 1'b1;
      ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;

      // Reset: all outputs low, then arready in the first released cycle.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
         chk($sformatf("rst arready L=%0d", i + 1), 32'(arready[i]), 32'd0);
         chk($sformatf("rst rvalid L=%0d", i + 1), 32'(rvalid[i]), 32'd0);
         chk($sformatf("rst rdata L=%0d", i + 1), rdata[i], 32'd0);
         chk($sformatf("rst rerr L=%0d", i + 1), 32'(rerr[i]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NL; i++)
         chk($sformatf("arready after rst L=%0d", i + 1), 32'(arready[i]), 32'd1);

      // Program image.
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         ld_we = 1'b1; ld_addr = lds[j].addr; ld_wdata = lds[j].data;
      end
      @(posedge clk); #1;
      ld_we = 1'b0;

      for (int j = 0; j < 10; j++)
         do_req(vecs[j].addr, vecs[j].burst, {NL{vecs[j].d0}}, vecs[j].d1,
                vecs[j].err, 1'b0, -1, 32'h0, 32'h0);

      // Abort in T+1: LATENCY 1 is already in its beat and completes.
      do_req(32'h30000000, 1'b0, {NL{32'h00000413}}, 32'h0, 1'b0, 1'b1, -1, 32'h0, 32'h0);
      do_req(32'h30000004, 1'b0, {NL{32'h00100493}}, 32'h0, 1'b0, 1'b0, -1, 32'h0, 32'h0);

      // Preload lands at the edge ending T+1: LATENCY 1 and 2 read old data.
      do_req(32'h30000008, 1'b0,
             {32'hAAAA0000, 32'hAAAA0000, 32'h11111111, 32'h11111111},
             32'h0, 1'b0, 1'b0, 1, 32'h30000008, 32'hAAAA0000);
      do_req(32'h30000008, 1'b0, {NL{32'hAAAA0000}}, 32'h0, 1'b0, 1'b0, -1, 32'h0, 32'h0);

      // Reset during BEAT0 of a LATENCY-2 burst: no further beats anywhere.
      @(posedge clk); #1;
      araddr = 32'h30000000; arburst = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      chk("pre-rst rvalid L=1", 32'(rvalid[0]), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
         chk($sformatf("midrst arready L=%0d", i + 1), 32'(arready[i]), 32'd0);
         chk($sformatf("midrst rvalid L=%0d", i + 1), 32'(rvalid[i]), 32'd0);
         chk($sformatf("midrst rdata L=%0d", i + 1), rdata[i], 32'd0);
         chk($sformatf("midrst rerr L=%0d", i + 1), 32'(rerr[i]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 3; k <= 7; k++) begin
         @(negedge clk);
         for (int i = 0; i < NL; i++) begin
            chk($sformatf("postrst rvalid L=%0d k=%0d", i + 1, k), 32'(rvalid[i]), 32'd0);
            chk($sformatf("postrst arready L=%0d k=%0d", i + 1, k), 32'(arready[i]), 32'd1);
         end
         @(posedge clk); #1;
      end
      do_req(32'h30000000, 1'b1, {NL{32'h00000413}}, 32'h00100493, 1'b0, 1'b0, -1, 32'h0, 32'h0);
      do_req(32'h30000008, 1'b0, {NL{32'hAAAA0000}}, 32'h0, 1'b0, 1'b0, -1, 32'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
